// File: rtl/conv_host_bridge_pkg.sv
// conv_host_bridge_pkg: shared widths, FSM encoding and bank codes for the host bridge
package conv_host_bridge_pkg;
  localparam int DATAW_DEF = 20;
  localparam int ADDRW_DEF = 12;
  localparam int RDY_TIMEOUT_DEF = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_RUN = 2'd2;
  localparam logic [1:0] S_FIN = 2'd3;
  localparam logic [2:0] BANK_IMG = 3'b000;
  localparam logic [2:0] BANK_L0K0 = 3'b001;
  localparam logic [2:0] BANK_L0K1 = 3'b010;
  localparam logic [2:0] BANK_L1K0 = 3'b011;
  localparam logic [2:0] BANK_L1K1 = 3'b100;
  localparam logic [2:0] BANK_L2 = 3'b101;
  // Only the five layer banks are addressable through csel; the image bank is read-only here.
  function automatic logic is_layer_bank(input logic [2:0] b);
    return b >= BANK_L0K0 && b <= BANK_L2;
  endfunction
endpackage

// File: rtl/conv_host_bridge_bank_decode.sv
// conv_bank_decode: maps csel to a layer-bank valid flag and the SRAM bank bits
module conv_bank_decode
  import conv_host_bridge_pkg::*;
(
  input  logic [2:0] csel_i,
  output logic       valid_o,
  output logic [2:0] bank_o
);
  assign valid_o = is_layer_bank(csel_i);
  assign bank_o = valid_o ? csel_i : BANK_IMG;
endmodule

// File: rtl/conv_host_bridge.sv
// conv_host_bridge: host/accelerator handshake FSM with SRAM image and layer-bank access
module conv_host_bridge
  import conv_host_bridge_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int ADDRW = ADDRW_DEF,
  parameter int RDY_TIMEOUT = RDY_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic             busy,
  input  logic [ADDRW-1:0] iaddr,
  output logic [DATAW-1:0] idata,
  input  logic             cwr,
  input  logic [ADDRW-1:0] caddr_wr,
  input  logic [DATAW-1:0] cdata_wr,
  input  logic             crd,
  input  logic [ADDRW-1:0] caddr_rd,
  output logic [DATAW-1:0] cdata_rd,
  input  logic [2:0]       csel,
  output logic [ADDRW+2:0] sram_raddr,
  output logic [ADDRW+2:0] sram_waddr,
  output logic             sram_we,
  output logic [DATAW-1:0] sram_wdata,
  input  logic [DATAW-1:0] sram_rdata,
  output logic             done,
  output logic             err
);
  localparam int CW = $clog2(RDY_TIMEOUT + 1);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic img_vld_q, lay_vld_q, fwd_q, fwd_d;
  logic [DATAW-1:0] idata_q, cdata_q, fwd_data_q;
  logic run, wr_ok, rd_ok, lay_rd, timeout;
  logic [2:0] wr_bank, rd_bank;
  conv_bank_decode u_wr_dec (.csel_i(csel), .valid_o(wr_ok), .bank_o(wr_bank));
  conv_bank_decode u_rd_dec (.csel_i(csel), .valid_o(rd_ok), .bank_o(rd_bank));
  assign run = state_q == S_RUN;
  assign sram_we = run & cwr & wr_ok;
  assign sram_waddr = {wr_bank, caddr_wr};
  assign sram_wdata = cdata_wr;
  assign lay_rd = run & crd & rd_ok;
  assign sram_raddr = lay_rd ? {rd_bank, caddr_rd} : {BANK_IMG, iaddr};
  // SRAM data lands one cycle after the address; the _q copies hold the last value between reads.
  assign idata = img_vld_q ? sram_rdata : idata_q;
  assign cdata_rd = lay_vld_q ? (fwd_q ? fwd_data_q : sram_rdata) : cdata_q;
  assign timeout = state_q == S_OFFER && !busy && cnt_q == CW'(RDY_TIMEOUT - 1);
  assign ready = ready_q;
  assign done = done_q;
  assign err = err_q;
  // Next-state: handshake sequencing, offer timeout and sticky error sources.
  always_comb begin
    state_d = state_q == S_IDLE  ? (start ? S_OFFER : S_IDLE)
            : state_q == S_OFFER ? (busy ? S_RUN : timeout ? S_IDLE : S_OFFER)
            : state_q == S_RUN   ? (busy ? S_RUN : S_FIN)
            : S_IDLE;
    cnt_d = (state_q == S_OFFER && !busy && !timeout) ? cnt_q + 1'b1 : '0;
    ready_d = state_d == S_OFFER;
    done_d = state_d == S_FIN;
    err_d = err_q | timeout | (run & cwr & !wr_ok);
    fwd_d = lay_rd & sram_we & (caddr_rd == caddr_wr);
  end
  // State, output and read-tracking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      ready_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      img_vld_q <= 1'b0;
      lay_vld_q <= 1'b0;
      fwd_q <= 1'b0;
      idata_q <= '0;
      cdata_q <= '0;
      fwd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      done_q <= done_d;
      err_q <= err_d;
      img_vld_q <= run & !lay_rd;
      lay_vld_q <= lay_rd;
      fwd_q <= fwd_d;
      idata_q <= idata;
      cdata_q <= cdata_rd;
      fwd_data_q <= cdata_wr;
    end
  end
endmodule

// File: tb/tb_conv_host_bridge.sv
// tb_conv_host_bridge: directed checks of handshake, timeout, SRAM access and reset
module tb_conv_host_bridge;
  logic clk = 0, reset = 1, start = 0, busy = 0, cwr = 0, crd = 0;
  logic ready, done, err, sram_we;
  logic [11:0] iaddr = 0, caddr_wr = 0, caddr_rd = 0;
  logic [19:0] cdata_wr = 0, idata, cdata_rd, sram_wdata, sram_rdata;
  logic [2:0] csel = 0;
  logic [14:0] sram_raddr, sram_waddr;
  logic [19:0] mem [0:32767];
  int total = 0, bad = 0;
  conv_host_bridge dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .sram_raddr(sram_raddr), .sram_waddr(sram_waddr), .sram_we(sram_we),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (sram_we) mem[sram_waddr] <= sram_wdata;
    sram_rdata <= mem[sram_raddr];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic go_run;
    start = 1;
    tick;
    start = 0;
    busy = 1;
    tick;
  endtask
  task automatic test_reset;
    cwr = 1;
    csel = 3'b001;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_idata", idata, 0);
    chk("rst_cdata", cdata_rd, 0);
    chk("rst_we", sram_we, 0);
    cwr = 0;
    tick;
    reset = 0;
    tick;
  endtask
  task automatic test_handshake;
    start = 1;
    tick;
    start = 0;
    chk("hs_ready_rise", ready, 1);
    tick;
    tick;
    chk("hs_ready_hold", ready, 1);
    busy = 1;
    tick;
    chk("hs_ready_drop", ready, 0);
    start = 1;
    tick;
    start = 0;
    chk("hs_run_ready", ready, 0);
    chk("hs_run_done", done, 0);
    busy = 0;
    tick;
    chk("hs_done", done, 1);
    tick;
    chk("hs_done_one", done, 0);
    chk("hs_start_ignored", ready, 0);
  endtask
  task automatic test_outside_run;
    cwr = 1;
    crd = 1;
    csel = 3'b001;
    #1;
    chk("idle_we", sram_we, 0);
    tick;
    cwr = 0;
    crd = 0;
    chk("idle_err", err, 0);
    chk("idle_cdata", cdata_rd, 0);
  endtask
  task automatic test_timeout;
    start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 15; i++) tick;
    chk("to_ready_15", ready, 1);
    chk("to_err_15", err, 0);
    tick;
    chk("to_ready_16", ready, 0);
    chk("to_err_16", err, 1);
    start = 1;
    tick;
    start = 0;
    chk("to_restart", ready, 1);
    reset = 1;
    #1;
    chk("to_err_clear", err, 0);
    reset = 0;
    tick;
  endtask
  task automatic test_image_read;
    mem[15'h0041] = 20'h12345;
    mem[15'h0042] = 20'h0ABCD;
    go_run;
    iaddr = 12'h041;
    tick;
    chk("img_041", idata, 20'h12345);
    iaddr = 12'h042;
    tick;
    chk("img_042", idata, 20'h0ABCD);
  endtask
  task automatic test_write;
    cwr = 1;
    csel = 3'b011;
    caddr_wr = 12'h7FF;
    cdata_wr = 20'h00ABC;
    #1;
    chk("wr_we", sram_we, 1);
    chk("wr_waddr", sram_waddr, 15'h37FF);
    chk("wr_wdata", sram_wdata, 20'h00ABC);
    tick;
    chk("wr_mem", mem[15'h37FF], 20'h00ABC);
    chk("wr_err_ok", err, 0);
    csel = 3'b000;
    #1;
    chk("wr_bank0_we", sram_we, 0);
    csel = 3'b110;
    #1;
    chk("wr_bad_we", sram_we, 0);
    tick;
    cwr = 0;
    chk("wr_bad_err", err, 1);
    crd = 1;
    csel = 3'b011;
    caddr_rd = 12'h7FF;
    tick;
    crd = 0;
    chk("rd_layer", cdata_rd, 20'h00ABC);
    tick;
    chk("rd_hold", cdata_rd, 20'h00ABC);
    reset = 1;
    #1;
    reset = 0;
    tick;
  endtask
  task automatic test_raw_hazard;
    mem[15'h1010] = 20'h11111;
    go_run;
    iaddr = 12'h041;
    tick;
    chk("raw_img_pre", idata, 20'h12345);
    crd = 1;
    cwr = 1;
    csel = 3'b001;
    caddr_rd = 12'h010;
    caddr_wr = 12'h010;
    cdata_wr = 20'h0FFFF;
    iaddr = 12'h042;
    #1;
    chk("raw_raddr", sram_raddr, 15'h1010);
    tick;
    crd = 0;
    cwr = 0;
    chk("raw_fwd", cdata_rd, 20'h0FFFF);
    chk("raw_img_hold", idata, 20'h12345);
    chk("raw_err", err, 0);
  endtask
  task automatic test_reset_mid_run;
    cwr = 1;
    csel = 3'b010;
    #1;
    chk("mid_we_pre", sram_we, 1);
    reset = 1;
    #1;
    chk("mid_we", sram_we, 0);
    chk("mid_ready", ready, 0);
    chk("mid_done", done, 0);
    chk("mid_err", err, 0);
    chk("mid_idata", idata, 0);
    chk("mid_cdata", cdata_rd, 0);
    cwr = 0;
    busy = 0;
    reset = 0;
    start = 1;
    tick;
    start = 0;
    chk("mid_restart", ready, 1);
  endtask
  initial begin
    test_reset;
    test_handshake;
    test_outside_run;
    test_timeout;
    test_image_read;
    test_write;
    test_raw_hazard;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
